sm83_mcycle_seq: RTL

//  M-cycle sequencer for the SM83 core. Consumes the decoder's per-instruction class flags and steps
//  the instruction through its M-cycles. Issues one memory access per M-cycle with a req/ack stall,

---
 rtl/sm83_mcycle_seq.sv | 306 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/sm83_mcycle_seq.sv
// ---------------------------------------------------------------------------
// sm83_mcycle_seq
//   M-cycle sequencer for the SM83 core. Takes the decoder's instruction
//   class flags and steps each instruction through its M-cycles. It issues
//   one memory access per M-cycle with a req/ack stall, overlaps the next
//   opcode fetch with the last M-cycle, and parks the core in HALT until wake.
//
//   Optional feature macro: SM83_SEQ_INTR_EN
//     defined   : a fetch ack with wake=1 enters a 5 M-cycle interrupt
//                 dispatch (INTR); wake out of HALT also enters INTR.
//     undefined : no INTR state, wake only ends HALT.
//
// Parameters
//   MCYC_W     width of the m_cycle counter (must hold 0..5)
//   FETCH_PC0  1: fetch right after reset, 0: wait in IDLE for start_i
//
// Ports
//   clk_i          core clock, one sequencer step per clock
//   reset_i        synchronous active-high reset
//   start_i        leave IDLE and begin fetching (FETCH_PC0=0 only)
//   dec_i[18:0]    decoder class flags, lowest set bit wins
//   cond_true_i    condition result, sampled in the decision M-cycle
//   wake_i         pending-interrupt level, ends HALT
//   mem_ack_i      current access completes this clock
//   mem_req_o      memory access active this M-cycle
//   mem_wr_o       access is a write
//   fetch_o        access is an opcode fetch
//   m_cycle_o      M-cycle index within the instruction
//   instr_done_o   one-clock pulse after an acked opcode fetch
//   halted_o       sequencer is halted
//
// State    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for start_i, bus quiet
// FETCH    | stand-alone opcode fetch (after reset, HALT or IDLE)
// EXEC     | instruction M-cycles; the last one is the overlapped fetch
// HALTED   | bus quiet until wake_i
// INTR     | interrupt dispatch: 2 internal, 2 writes, vector fetch
// ---------------------------------------------------------------------------
module sm83_mcycle_seq #(
  parameter int MCYC_W    = 3,
  parameter bit FETCH_PC0 = 1'b1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [18:0]       dec_i,
  input  logic              cond_true_i,
  input  logic              wake_i,
  input  logic              mem_ack_i,
  output logic              mem_req_o,
  output logic              mem_wr_o,
  output logic              fetch_o,
  output logic [MCYC_W-1:0] m_cycle_o,
  output logic              instr_done_o,
  output logic              halted_o
);

`ifdef SM83_SEQ_INTR_EN
  typedef enum logic [2:0] {ST_IDLE, ST_FETCH, ST_EXEC, ST_HALTED, ST_INTR} state_e;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_EXEC, ST_HALTED} state_e;
`endif

  typedef enum logic [4:0] {
    C_NONE, C_ADD_HL, C_LD_R_HL, C_LD_HL_R, C_LD_R_N, C_LD_HL_N, C_INC_HL,
    C_PUSH, C_POP, C_JP_NN, C_JP_CC, C_JR_E, C_JR_CC, C_CALL_NN, C_CALL_CC,
    C_RET, C_RETI, C_RET_CC, C_RST, C_HALT
  } cls_e;

  localparam logic [MCYC_W-1:0] M0 = MCYC_W'(0);
  localparam logic [MCYC_W-1:0] M1 = MCYC_W'(1);
  localparam logic [MCYC_W-1:0] M2 = MCYC_W'(2);
  localparam logic [MCYC_W-1:0] M3 = MCYC_W'(3);
  localparam logic [MCYC_W-1:0] M4 = MCYC_W'(4);
  localparam logic [MCYC_W-1:0] M5 = MCYC_W'(5);
  localparam logic [MCYC_W-1:0] M6 = MCYC_W'(6);

  state_e              state_q, state_d;
  logic [MCYC_W-1:0]   m_cycle_q, m_cycle_d;
  logic                taken_q, taken_d;
  logic                instr_done_q, instr_done_d;

  cls_e                cls;
  logic [MCYC_W-1:0]   len;
  logic [MCYC_W-1:0]   cond_m;
  logic                is_cond;
  logic                exec_last;
  logic                exec_int;
  logic                exec_wr;
  logic                req_c;
  logic                wr_c;
  logic                fetch_c;
  logic                halt_c;
  logic                step_ok;
  logic                fetch_ack;

  // Lowest flag index wins, so test from bit 0 upwards.
  always_comb begin
    if      (dec_i[0])  cls = C_ADD_HL;
    else if (dec_i[1])  cls = C_LD_R_HL;
    else if (dec_i[2])  cls = C_LD_HL_R;
    else if (dec_i[3])  cls = C_LD_R_N;
    else if (dec_i[4])  cls = C_LD_HL_N;
    else if (dec_i[5])  cls = C_INC_HL;
    else if (dec_i[6])  cls = C_PUSH;
    else if (dec_i[7])  cls = C_POP;
    else if (dec_i[8])  cls = C_JP_NN;
    else if (dec_i[9])  cls = C_JP_CC;
    else if (dec_i[10]) cls = C_JR_E;
    else if (dec_i[11]) cls = C_JR_CC;
    else if (dec_i[12]) cls = C_CALL_NN;
    else if (dec_i[13]) cls = C_CALL_CC;
    else if (dec_i[14]) cls = C_RET;
    else if (dec_i[15]) cls = C_RETI;
    else if (dec_i[16]) cls = C_RET_CC;
    else if (dec_i[17]) cls = C_RST;
    else if (dec_i[18]) cls = C_HALT;
    else                cls = C_NONE;
  end

  // Instruction length including the overlapped fetch. For conditional
  // classes taken_q is only meaningful after the decision cycle; before it
  // both lengths put the final cycle beyond the current m_cycle.
  always_comb begin
    len     = M1;
    cond_m  = M0;
    is_cond = 1'b0;
    case (cls)
      C_ADD_HL, C_LD_R_HL, C_LD_HL_R, C_LD_R_N: len = M2;
      C_LD_HL_N, C_INC_HL, C_POP, C_JR_E:      len = M3;
      C_PUSH, C_JP_NN, C_RET, C_RETI, C_RST:   len = M4;
      C_CALL_NN:                               len = M6;
      C_JR_CC: begin
        is_cond = 1'b1;
        len     = taken_q ? M3 : M2;
      end
      C_JP_CC: begin
        is_cond = 1'b1;
        cond_m  = M1;
        len     = taken_q ? M4 : M3;
      end
      C_CALL_CC: begin
        is_cond = 1'b1;
        cond_m  = M1;
        len     = taken_q ? M6 : M3;
      end
      C_RET_CC: begin
        is_cond = 1'b1;
        len     = taken_q ? M5 : M2;
      end
      default: len = M1;
    endcase
  end

  assign exec_last = (m_cycle_q == len - M1);

  // Non-final cycle kind. The final (fetch) cycle overrides these, which is
  // what truncates not-taken jumps/calls.
  always_comb begin
    exec_int = 1'b0;
    exec_wr  = 1'b0;
    case (cls)
      C_LD_HL_R:            exec_wr  = (m_cycle_q == M0);
      C_LD_HL_N, C_INC_HL:  exec_wr  = (m_cycle_q == M1);
      C_PUSH, C_RST: begin
        exec_int = (m_cycle_q == M0);
        exec_wr  = (m_cycle_q == M1) || (m_cycle_q == M2);
      end
      C_JP_NN, C_JP_CC:     exec_int = (m_cycle_q == M2);
      C_JR_E, C_JR_CC:      exec_int = (m_cycle_q == M1);
      C_CALL_NN, C_CALL_CC: begin
        exec_int = (m_cycle_q == M2);
        exec_wr  = (m_cycle_q == M3) || (m_cycle_q == M4);
      end
      C_RET, C_RETI:        exec_int = (m_cycle_q == M2);
      C_RET_CC:             exec_int = (m_cycle_q == M0) || (m_cycle_q == M3);
      default: begin
        exec_int = 1'b0;
        exec_wr  = 1'b0;
      end
    endcase
  end

  // Bus controls are decoded from the registered state and the live flags:
  // the flags of a new instruction only appear the clock after its fetch
  // ack, which is already its first M-cycle.
  always_comb begin
    req_c   = 1'b0;
    wr_c    = 1'b0;
    fetch_c = 1'b0;
    halt_c  = 1'b0;
    case (state_q)
      ST_FETCH: begin
        req_c   = 1'b1;
        fetch_c = 1'b1;
      end
      ST_EXEC: begin
        if (cls == C_HALT) begin
          halt_c = 1'b1;
        end else if (exec_last) begin
          req_c   = 1'b1;
          fetch_c = 1'b1;
        end else if (!exec_int) begin
          req_c = 1'b1;
          wr_c  = exec_wr;
        end
      end
      ST_HALTED: halt_c = 1'b1;
`ifdef SM83_SEQ_INTR_EN
      ST_INTR: begin
        if (m_cycle_q == M4) begin
          req_c   = 1'b1;
          fetch_c = 1'b1;
        end else if ((m_cycle_q == M2) || (m_cycle_q == M3)) begin
          req_c = 1'b1;
          wr_c  = 1'b1;
        end
      end
`endif
      default: begin
        req_c   = 1'b0;
        fetch_c = 1'b0;
      end
    endcase
  end

  // Internal cycles have no bus handshake and always advance.
  assign step_ok   = !req_c || mem_ack_i;
  assign fetch_ack = fetch_c && mem_ack_i;

  always_comb begin
    state_d      = state_q;
    m_cycle_d    = m_cycle_q;
    taken_d      = taken_q;
    instr_done_d = 1'b0;
    if (fetch_ack) begin
      instr_done_d = 1'b1;
      m_cycle_d    = M0;
      taken_d      = 1'b0;
      state_d      = ST_EXEC;
`ifdef SM83_SEQ_INTR_EN
      if (wake_i && (state_q != ST_INTR)) state_d = ST_INTR;
`endif
    end else begin
      case (state_q)
        ST_IDLE: if (start_i) state_d = ST_FETCH;
        ST_EXEC: begin
          if (cls == C_HALT) begin
            m_cycle_d = M0;
            if (!wake_i) begin
              state_d = ST_HALTED;
            end else begin
`ifdef SM83_SEQ_INTR_EN
              state_d = ST_INTR;
`else
              state_d = ST_FETCH;
`endif
            end
          end else if (step_ok) begin
            m_cycle_d = m_cycle_q + M1;
            // Last cond_true before the ack is the one that counts.
            if (is_cond && (m_cycle_q == cond_m)) taken_d = cond_true_i;
          end
        end
        ST_HALTED: begin
          if (wake_i) begin
            m_cycle_d = M0;
`ifdef SM83_SEQ_INTR_EN
            state_d = ST_INTR;
`else
            state_d = ST_FETCH;
`endif
          end
        end
`ifdef SM83_SEQ_INTR_EN
        ST_INTR: if (step_ok) m_cycle_d = m_cycle_q + M1;
`endif
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= FETCH_PC0 ? ST_FETCH : ST_IDLE;
      m_cycle_q    <= M0;
      taken_q      <= 1'b0;
      instr_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      m_cycle_q    <= m_cycle_d;
      taken_q      <= taken_d;
      instr_done_q <= instr_done_d;
    end
  end

  // Reset drops the access in the same clock it is asserted.
  assign mem_req_o    = req_c   && !reset_i;
  assign mem_wr_o     = wr_c    && !reset_i;
  assign fetch_o      = fetch_c && !reset_i;
  assign halted_o     = halt_c  && !reset_i;
  assign instr_done_o = instr_done_q && !reset_i;
  assign m_cycle_o    = reset_i ? M0 : m_cycle_q;

endmodule
